// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path: FSM state encoding,
// parity selectors, legal oversampling ratios and the majority-vote helper.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam int PRESC_8  = 8;
    localparam int PRESC_16 = 16;
    localparam int PRESC_32 = 32;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit edge counter and three-point mid-bit sampler with 2-of-3 majority vote.
// sampled_bit is stable from the cycle after sample_done until the next bit's vote.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int PRESC_W = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               rx,
    input  logic               active,
    input  logic [PRESC_W-1:0] prescale,
    output logic               bit_end,
    output logic               sampled_bit,
    output logic               sample_done
);

    localparam logic [PRESC_W-1:0] ONE = {{(PRESC_W-1){1'b0}}, 1'b1};

    logic [PRESC_W-1:0] edge_cnt_r;
    logic [PRESC_W-1:0] half_s;
    logic [PRESC_W-1:0] mid_lo_s;
    logic [PRESC_W-1:0] mid_hi_s;
    logic [PRESC_W-1:0] last_s;
    logic               bit_end_s;
    logic               s0_r;
    logic               s1_r;
    logic               sampled_bit_r;
    logic               sample_done_r;

    assign half_s    = {1'b0, prescale[PRESC_W-1:1]};
    assign mid_lo_s  = half_s - ONE;
    assign mid_hi_s  = half_s + ONE;
    assign last_s    = prescale - ONE;
    assign bit_end_s = active && (edge_cnt_r == last_s);

    // Edge counter: parked at zero while idle, wraps at the last edge of each bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_cnt_r <= {PRESC_W{1'b0}};
        end else if (!active || bit_end_s) begin
            edge_cnt_r <= {PRESC_W{1'b0}};
        end else begin
            edge_cnt_r <= edge_cnt_r + ONE;
        end
    end

    // Three mid-bit samples; the vote is taken together with the third sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_r          <= 1'b0;
            s1_r          <= 1'b0;
            sampled_bit_r <= 1'b0;
            sample_done_r <= 1'b0;
        end else begin
            sample_done_r <= 1'b0;
            if (active) begin
                if (edge_cnt_r == mid_lo_s) begin
                    s0_r <= rx;
                end
                if (edge_cnt_r == half_s) begin
                    s1_r <= rx;
                end
                if (edge_cnt_r == mid_hi_s) begin
                    sampled_bit_r <= majority3(s0_r, s1_r, rx);
                    sample_done_r <= 1'b1;
                end
            end
        end
    end

    assign bit_end     = bit_end_s;
    assign sampled_bit = sampled_bit_r;
    assign sample_done = sample_done_r;

endmodule

// File: rtl/uart_rx_frame.sv
// UART frame receiver: start / DATA_WIDTH data bits LSB-first / optional parity / stop.
// Define RX_INPUT_SYNC_EN to pass rx_in through a 2-flop synchroniser first.
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PRESC_W    = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx_in,
    input  logic [PRESC_W-1:0]    prescale,
    input  logic                  par_en,
    input  logic                  par_typ,
    output logic [DATA_WIDTH-1:0] p_data,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err
);

    localparam int              CNT_W     = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH);

    function automatic logic expected_parity(input logic [DATA_WIDTH-1:0] d, input logic typ);
        return (typ == PAR_ODD) ? ~^d : ^d;
    endfunction

    rx_state_e             state_r;
    rx_state_e             next_state_s;
    logic                  rx_s;
    logic                  start_seen_s;
    logic                  active_s;
    logic                  bit_end_s;
    logic                  sampled_bit_s;
    logic                  sample_done_s;
    logic [PRESC_W-1:0]    presc_r;
    logic                  par_en_r;
    logic                  par_typ_r;
    logic [CNT_W-1:0]      bit_cnt_r;
    logic [DATA_WIDTH-1:0] shreg_r;
    logic                  par_mismatch_r;
    logic [DATA_WIDTH-1:0] p_data_r;
    logic                  data_valid_r;
    logic                  par_err_r;
    logic                  stp_err_r;

`ifdef RX_INPUT_SYNC_EN
    logic [1:0] sync_r;

    // Two-flop synchroniser; resets to the idle line level so reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= 2'b11;
        end else begin
            sync_r <= {sync_r[0], rx_in};
        end
    end

    assign rx_s = sync_r[1];
`else
    assign rx_s = rx_in;
`endif

    assign start_seen_s = (state_r == IDLE) && !rx_s;
    assign active_s     = (state_r != IDLE);

    uart_rx_sampler #(
        .PRESC_W (PRESC_W)
    ) u_sampler (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx          (rx_s),
        .active      (active_s),
        .prescale    (presc_r),
        .bit_end     (bit_end_s),
        .sampled_bit (sampled_bit_s),
        .sample_done (sample_done_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; every state except IDLE moves only on the last edge of a bit.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (!rx_s) begin
                    next_state_s = START;
                end else begin
                    next_state_s = IDLE;
                end
            end
            START: begin
                if (bit_end_s) begin
                    next_state_s = sampled_bit_s ? IDLE : DATA;
                end else begin
                    next_state_s = START;
                end
            end
            DATA: begin
                if (bit_end_s && (bit_cnt_r == CNT_LAST)) begin
                    next_state_s = par_en_r ? PARITY : STOP;
                end else begin
                    next_state_s = DATA;
                end
            end
            PARITY: begin
                if (bit_end_s) begin
                    next_state_s = STOP;
                end else begin
                    next_state_s = PARITY;
                end
            end
            STOP: begin
                // A low line on the final stop edge is already the next start bit.
                if (bit_end_s) begin
                    next_state_s = rx_s ? IDLE : START;
                end else begin
                    next_state_s = STOP;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Frame configuration is latched only when a start edge is seen from IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_r   <= PRESC_W'(PRESC_8);
            par_en_r  <= 1'b0;
            par_typ_r <= PAR_EVEN;
        end else if (start_seen_s) begin
            presc_r   <= prescale;
            par_en_r  <= par_en;
            par_typ_r <= par_typ;
        end
    end

    // Datapath: bit counting, deserialisation, parity check and frame verdict pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_r      <= {CNT_W{1'b0}};
            shreg_r        <= {DATA_WIDTH{1'b0}};
            par_mismatch_r <= 1'b0;
            p_data_r       <= {DATA_WIDTH{1'b0}};
            data_valid_r   <= 1'b0;
            par_err_r      <= 1'b0;
            stp_err_r      <= 1'b0;
        end else begin
            data_valid_r <= 1'b0;
            par_err_r    <= 1'b0;
            stp_err_r    <= 1'b0;
            case (state_r)
                START: begin
                    if (bit_end_s) begin
                        bit_cnt_r      <= {CNT_W{1'b0}};
                        par_mismatch_r <= 1'b0;
                    end
                end
                DATA: begin
                    if (sample_done_s) begin
                        shreg_r   <= {sampled_bit_s, shreg_r[DATA_WIDTH-1:1]};
                        bit_cnt_r <= bit_cnt_r + CNT_ONE;
                    end
                end
                PARITY: begin
                    if (sample_done_s) begin
                        par_mismatch_r <= (sampled_bit_s != expected_parity(shreg_r, par_typ_r));
                    end
                end
                STOP: begin
                    if (bit_end_s) begin
                        if (sampled_bit_s && !par_mismatch_r) begin
                            p_data_r     <= shreg_r;
                            data_valid_r <= 1'b1;
                        end else begin
                            par_err_r <= par_mismatch_r;
                            stp_err_r <= !sampled_bit_s;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign p_data     = p_data_r;
    assign data_valid = data_valid_r;
    assign par_err    = par_err_r;
    assign stp_err    = stp_err_r;

endmodule
